// File: rtl/fpaddsub_pkg.sv
// fpaddsub_pkg
//   Shared definitions for the FPAddSub datapath: default mantissa width,
//   rounding-mode encoding with the mode used for the sign of an exact-zero
//   difference, and the effective-operation / carry-in decode helper.
package fpaddsub_pkg;

  localparam int unsigned MW_DEF = 25;

  typedef enum logic [1:0] {
    RM_RNE = 2'd0,
    RM_RTZ = 2'd1,
    RM_RDN = 2'd2,
    RM_RUP = 2'd3
  } round_mode_e;

  localparam round_mode_e ROUND_MODE = RM_RNE;

  // x - x yields +0 in every mode except round-down, which yields -0.
  function automatic logic zero_sign(input round_mode_e rm);
    return (rm == RM_RDN);
  endfunction

  typedef struct packed {
    logic opr;  // effective subtract
    logic opc;  // carry-in completing the two's complement
  } opctl_t;

  // Without guard/sticky the one's complement needs +1; a nonzero
  // shifted-out tail already borrows one, so the +1 is dropped.
  function automatic opctl_t decode_op(input logic op_mode, input logic sa,
                                       input logic sb, input logic g,
                                       input logic s);
    opctl_t r;
    r.opr = op_mode ^ sa ^ sb;
    r.opc = r.opr & ~(g | s);
    return r;
  endfunction

endpackage

// File: rtl/fpaddsub_split_adder.sv
// fpaddsub_split_adder
//   Combinational adder split into a low half (LSPLIT bits, carry out) and
//   a high half (W-LSPLIT bits, carry in, carry out discarded). The caller
//   decides whether a register sits between the two halves.
// Ports:
//   lo_a, lo_b, lo_cin -> lo_sum, lo_cout   low half
//   hi_a, hi_b, hi_cin -> hi_sum            high half, result mod 2^(W-LSPLIT)
module fpaddsub_split_adder #(
  parameter int unsigned W      = 26,
  parameter int unsigned LSPLIT = 13
) (
  input  logic [LSPLIT-1:0]   lo_a,
  input  logic [LSPLIT-1:0]   lo_b,
  input  logic                lo_cin,
  output logic [LSPLIT-1:0]   lo_sum,
  output logic                lo_cout,
  input  logic [W-LSPLIT-1:0] hi_a,
  input  logic [W-LSPLIT-1:0] hi_b,
  input  logic                hi_cin,
  output logic [W-LSPLIT-1:0] hi_sum
);

  localparam int unsigned HW = W - LSPLIT;

  always_comb begin
    {lo_cout, lo_sum} = {1'b0, lo_a} + {1'b0, lo_b} + {{LSPLIT{1'b0}}, lo_cin};
    hi_sum = hi_a + hi_b + {{(HW-1){1'b0}}, hi_cin};
  end

endmodule

// File: rtl/fpaddsub_execute_pipe.sv
// fpaddsub_execute_pipe
//   Mantissa add/subtract execute stage between alignment and normalisation.
//   Resolves the effective operation, forms the compensated mantissa sum,
//   the result sign and an exact-zero flag. Valid/ready handshake with a
//   global stall; optional register between the adder halves (STAGES=2).
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         input handshake
//   mmax, mmin                aligned mantissas (mmax is the larger)
//   sa, sb, max_ab, op_mode   operand signs, larger-operand select, add/sub
//   g, s                      guard and sticky of shifted mmin
//   in_tag / out_tag          opaque sideband carried with the beat
//   out_valid/out_ready       output handshake
//   sum, sgn, zero, eff_sub   mantissa result, sign, zero flag, eff. subtract
module fpaddsub_execute_pipe
  import fpaddsub_pkg::*;
#(
  parameter int unsigned MW     = MW_DEF,
  parameter int unsigned STAGES = 1,
  parameter int unsigned LSPLIT = 13,
  parameter int unsigned TAGW   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [MW-1:0]   mmax,
  input  logic [MW-1:0]   mmin,
  input  logic            sa,
  input  logic            sb,
  input  logic            max_ab,
  input  logic            op_mode,
  input  logic            g,
  input  logic            s,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [MW:0]     sum,
  output logic            sgn,
  output logic            zero,
  output logic            eff_sub,
  output logic [TAGW-1:0] out_tag
);

  localparam int unsigned SW = MW + 1;
  localparam int unsigned HW = SW - LSPLIT;

  if (!(STAGES == 1 || STAGES == 2)) begin : g_bad_stages
    $error("fpaddsub_execute_pipe: STAGES must be 1 or 2");
  end
  if (LSPLIT < 1 || LSPLIT > MW - 1) begin : g_bad_lsplit
    $error("fpaddsub_execute_pipe: LSPLIT must be in 1..MW-1");
  end

  logic out_valid_q, out_valid_d;
  logic [SW-1:0] sum_q, sum_d;
  logic sgn_q, sgn_d, zero_q, zero_d, eff_sub_q, eff_sub_d;
  logic [TAGW-1:0] out_tag_q, out_tag_d;
  logic advance;

  assign in_ready = ~out_valid_q | out_ready;
  assign advance  = in_ready;

  // Input-side decode
  opctl_t ctl_in;
  logic [SW-1:0] a_ext, b_ext;
  logic sign_in, gs_in;

  always_comb begin
    ctl_in  = decode_op(op_mode, sa, sb, g, s);
    a_ext   = {1'b0, mmax};
    b_ext   = ctl_in.opr ? ~{1'b0, mmin} : {1'b0, mmin};
    sign_in = max_ab ? sb : sa;
    gs_in   = g | s;
  end

  logic [LSPLIT-1:0] lo_sum;
  logic              lo_cout;
  logic [HW-1:0]     hi_a, hi_b, hi_sum;
  logic              hi_cin;

  fpaddsub_split_adder #(
    .W      (SW),
    .LSPLIT (LSPLIT)
  ) u_adder (
    .lo_a    (a_ext[LSPLIT-1:0]),
    .lo_b    (b_ext[LSPLIT-1:0]),
    .lo_cin  (ctl_in.opc),
    .lo_sum  (lo_sum),
    .lo_cout (lo_cout),
    .hi_a    (hi_a),
    .hi_b    (hi_b),
    .hi_cin  (hi_cin),
    .hi_sum  (hi_sum)
  );

  // Signals presented to the output register by the last stage
  logic              fin_valid;
  logic [LSPLIT-1:0] fin_lo;
  logic              fin_opr, fin_gs, fin_sign;
  logic [TAGW-1:0]   fin_tag;

  if (STAGES == 2) begin : g_two
    logic              v1_q, v1_d;
    logic [LSPLIT-1:0] lo_sum_q, lo_sum_d;
    logic              lo_cout_q, lo_cout_d;
    logic [HW-1:0]     hi_a_q, hi_a_d, hi_b_q, hi_b_d;
    logic              opr_q, opr_d, gs_q, gs_d, sign_q, sign_d;
    logic [TAGW-1:0]   tag_q, tag_d;

    always_comb begin
      v1_d      = v1_q;
      lo_sum_d  = lo_sum_q;
      lo_cout_d = lo_cout_q;
      hi_a_d    = hi_a_q;
      hi_b_d    = hi_b_q;
      opr_d     = opr_q;
      gs_d      = gs_q;
      sign_d    = sign_q;
      tag_d     = tag_q;
      if (advance) begin
        v1_d = in_valid;
        if (in_valid) begin
          lo_sum_d  = lo_sum;
          lo_cout_d = lo_cout;
          hi_a_d    = a_ext[SW-1:LSPLIT];
          hi_b_d    = b_ext[SW-1:LSPLIT];
          opr_d     = ctl_in.opr;
          gs_d      = gs_in;
          sign_d    = sign_in;
          tag_d     = in_tag;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v1_q      <= 1'b0;
        lo_sum_q  <= '0;
        lo_cout_q <= 1'b0;
        hi_a_q    <= '0;
        hi_b_q    <= '0;
        opr_q     <= 1'b0;
        gs_q      <= 1'b0;
        sign_q    <= 1'b0;
        tag_q     <= '0;
      end else begin
        v1_q      <= v1_d;
        lo_sum_q  <= lo_sum_d;
        lo_cout_q <= lo_cout_d;
        hi_a_q    <= hi_a_d;
        hi_b_q    <= hi_b_d;
        opr_q     <= opr_d;
        gs_q      <= gs_d;
        sign_q    <= sign_d;
        tag_q     <= tag_d;
      end
    end

    assign hi_a      = hi_a_q;
    assign hi_b      = hi_b_q;
    assign hi_cin    = lo_cout_q;
    assign fin_valid = v1_q;
    assign fin_lo    = lo_sum_q;
    assign fin_opr   = opr_q;
    assign fin_gs    = gs_q;
    assign fin_sign  = sign_q;
    assign fin_tag   = tag_q;
  end else begin : g_one
    assign hi_a      = a_ext[SW-1:LSPLIT];
    assign hi_b      = b_ext[SW-1:LSPLIT];
    assign hi_cin    = lo_cout;
    assign fin_valid = in_valid;
    assign fin_lo    = lo_sum;
    assign fin_opr   = ctl_in.opr;
    assign fin_gs    = gs_in;
    assign fin_sign  = sign_in;
    assign fin_tag   = in_tag;
  end

  // Final result formation and output register
  logic [SW-1:0] fin_sum;
  logic          fin_zero, fin_sgn;

  always_comb begin
    fin_sum  = {hi_sum, fin_lo};
    fin_zero = (fin_sum == '0) & ~fin_gs;
    fin_sgn  = (fin_zero & fin_opr) ? zero_sign(ROUND_MODE) : fin_sign;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    sgn_d       = sgn_q;
    zero_d      = zero_q;
    eff_sub_d   = eff_sub_q;
    out_tag_d   = out_tag_q;
    if (advance) begin
      out_valid_d = fin_valid;
      if (fin_valid) begin
        sum_d     = fin_sum;
        sgn_d     = fin_sgn;
        zero_d    = fin_zero;
        eff_sub_d = fin_opr;
        out_tag_d = fin_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      sgn_q       <= 1'b0;
      zero_q      <= 1'b0;
      eff_sub_q   <= 1'b0;
      out_tag_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      sgn_q       <= sgn_d;
      zero_q      <= zero_d;
      eff_sub_q   <= eff_sub_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign sgn       = sgn_q;
  assign zero      = zero_q;
  assign eff_sub   = eff_sub_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_fpaddsub_execute_pipe.sv
// tb_fpaddsub_execute_pipe
//   Bench for fpaddsub_execute_pipe: one instance with STAGES=1 and one with
//   STAGES=2/LSPLIT=13, sharing operand inputs with separate handshakes.
module tb_fpaddsub_execute_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid1, in_valid2, out_ready1, out_ready2;
  logic        in_ready1, in_ready2, out_valid1, out_valid2;
  logic [24:0] mmax, mmin;
  logic        sa, sb, max_ab, op_mode, g, s;
  logic [7:0]  in_tag, out_tag1, out_tag2;
  logic [25:0] sum1, sum2;
  logic        sgn1, sgn2, zero1, zero2, eff1, eff2;

  always #5 clk = ~clk;

  fpaddsub_execute_pipe #(.MW(25), .STAGES(1), .LSPLIT(13), .TAGW(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .mmax(mmax), .mmin(mmin), .sa(sa), .sb(sb), .max_ab(max_ab),
    .op_mode(op_mode), .g(g), .s(s), .in_tag(in_tag),
    .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1), .sgn(sgn1),
    .zero(zero1), .eff_sub(eff1), .out_tag(out_tag1)
  );

  fpaddsub_execute_pipe #(.MW(25), .STAGES(2), .LSPLIT(13), .TAGW(8)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .mmax(mmax), .mmin(mmin), .sa(sa), .sb(sb), .max_ab(max_ab),
    .op_mode(op_mode), .g(g), .s(s), .in_tag(in_tag),
    .out_valid(out_valid2), .out_ready(out_ready2), .sum(sum2), .sgn(sgn2),
    .zero(zero2), .eff_sub(eff2), .out_tag(out_tag2)
  );

  // Observation mux selecting the instance under test
  int          sel = 1;
  logic        o_valid, o_ready, o_sgn, o_zero, o_eff;
  logic [25:0] o_sum;
  logic [7:0]  o_tag;

  always_comb begin
    if (sel == 2) begin
      o_valid = out_valid2; o_ready = in_ready2; o_sum = sum2;
      o_sgn = sgn2; o_zero = zero2; o_eff = eff2; o_tag = out_tag2;
    end else begin
      o_valid = out_valid1; o_ready = in_ready1; o_sum = sum1;
      o_sgn = sgn1; o_zero = zero1; o_eff = eff1; o_tag = out_tag1;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [24:0] mx, mn;
    logic sa, sb, mab, op, g, s;
    logic [25:0] sum;
    logic sgn, zero, eff;
  } vec_t;

  // Hand-computed directed vectors
  vec_t dv[10];
  initial begin
    dv[0] = '{25'h1000000, 25'h0800000, 0,0,0,0,0,0, 26'h1800000, 0,0,0};
    dv[1] = '{25'h1000000, 25'h0800000, 0,0,0,1,0,0, 26'h0800000, 0,0,1};
    dv[2] = '{25'h1000000, 25'h0800000, 0,0,0,1,1,0, 26'h07FFFFF, 0,0,1};
    dv[3] = '{25'h1234567, 25'h1234567, 1,1,0,1,0,0, 26'h0000000, 0,1,1};
    dv[4] = '{25'h1234567, 25'h1234567, 1,1,0,1,0,1, 26'h3FFFFFF, 1,0,1};
    dv[5] = '{25'h1FFFFFF, 25'h1FFFFFF, 0,0,0,0,0,0, 26'h3FFFFFE, 0,0,0};
    dv[6] = '{25'h0000010, 25'h0000003, 0,1,1,0,0,0, 26'h000000D, 1,0,1};
    dv[7] = '{25'h0000000, 25'h0000000, 1,1,0,0,0,0, 26'h0000000, 1,1,0};
    dv[8] = '{25'h0001FFF, 25'h0000001, 0,0,0,0,0,0, 26'h0002000, 0,0,0};
    dv[9] = '{25'h0002000, 25'h0000001, 0,0,0,1,0,0, 26'h0001FFF, 0,0,1};
  end

  typedef struct packed {
    logic [25:0] sum;
    logic sgn, zero, eff;
    logic [7:0] tag;
  } res_t;

  function automatic res_t model(input logic [24:0] mx, input logic [24:0] mn,
                                 input logic a_s, input logic b_s,
                                 input logic mab, input logic op,
                                 input logic gg, input logic ss,
                                 input logic [7:0] tg);
    res_t r;
    logic opr;
    logic [25:0] m, n;
    opr = op ^ a_s ^ b_s;
    m = {1'b0, mx};
    n = {1'b0, mn};
    r.sum  = opr ? (m - n - ((gg | ss) ? 26'd1 : 26'd0)) : (m + n);
    r.zero = (r.sum == 26'd0) && !gg && !ss;
    r.sgn  = (r.zero && opr) ? 1'b0 : (mab ? b_s : a_s);
    r.eff  = opr;
    r.tag  = tg;
    return r;
  endfunction

  task automatic drive_vec(input int i, input logic [7:0] tg);
    mmax = dv[i].mx; mmin = dv[i].mn; sa = dv[i].sa; sb = dv[i].sb;
    max_ab = dv[i].mab; op_mode = dv[i].op; g = dv[i].g; s = dv[i].s;
    in_tag = tg;
  endtask

  task automatic run_dir(input int which, input int i);
    sel = which;
    drive_vec(i, 8'h10 + 8'(i));
    if (which == 1) in_valid1 = 1'b1; else in_valid2 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0; in_valid2 = 1'b0;
    if (which == 2) begin
      check($sformatf("s2_d%0d_lat_early", i), o_valid, 1'b0);
      @(posedge clk); #1;
    end
    check($sformatf("s%0d_d%0d_valid", which, i), o_valid, 1'b1);
    check($sformatf("s%0d_d%0d_sum", which, i), o_sum, dv[i].sum);
    check($sformatf("s%0d_d%0d_sgn", which, i), o_sgn, dv[i].sgn);
    check($sformatf("s%0d_d%0d_zero", which, i), o_zero, dv[i].zero);
    check($sformatf("s%0d_d%0d_eff", which, i), o_eff, dv[i].eff);
    check($sformatf("s%0d_d%0d_tag", which, i), o_tag, 8'h10 + 8'(i));
  endtask

  // Streams nb beats through one instance against the model. With
  // stall_mid, out_ready is held low for 3 cycles mid-stream; otherwise
  // in_valid and out_ready are randomised.
  task automatic stream(input int which, input int nb, input bit stall_mid);
    res_t q[$];
    res_t exp_r, held;
    int sent = 0, got = 0, cyc = 0;
    bit vld, rdy, acc, con, stalled_prev = 0;
    sel = which;
    while (got < nb && cyc < nb * 8 + 50) begin
      vld = (sent < nb) && (stall_mid || $urandom_range(0, 4) != 0);
      if (stall_mid) begin
        mmax = 25'h0100000 + 25'(sent * 'h111);
        mmin = 25'(sent * 3);
        sa = sent[0]; sb = 1'b0; max_ab = sent[1]; op_mode = 1'b0;
        g = (sent == 3); s = 1'b0;
      end else begin
        mmax = 25'($urandom);
        mmin = ($urandom_range(0, 7) == 0) ? mmax : 25'($urandom);
        {sa, sb, max_ab, op_mode} = 4'($urandom);
        g = ($urandom_range(0, 2) == 0);
        s = ($urandom_range(0, 2) == 0);
      end
      in_tag = 8'(sent);
      rdy = stall_mid ? !(cyc >= 4 && cyc < 7) : ($urandom_range(0, 3) != 0);
      if (which == 1) begin in_valid1 = vld; out_ready1 = rdy; end
      else begin in_valid2 = vld; out_ready2 = rdy; end
      #1;
      if (stalled_prev) begin
        check("stall_hold_valid", o_valid, 1'b1);
        check("stall_hold_data", {o_sum, o_sgn, o_zero, o_eff, o_tag}, held);
      end
      stalled_prev = 0;
      if (o_valid && !rdy) begin
        check("stall_in_ready", o_ready, 1'b0);
        held = {o_sum, o_sgn, o_zero, o_eff, o_tag};
        stalled_prev = 1;
      end
      acc = vld && o_ready;
      con = o_valid && rdy;
      if (con) begin
        if (q.size() == 0) begin
          check("spurious_beat", 1'b1, 1'b0);
        end else begin
          exp_r = q.pop_front();
          check($sformatf("st%0d_sum", which), o_sum, exp_r.sum);
          check($sformatf("st%0d_sgn", which), o_sgn, exp_r.sgn);
          check($sformatf("st%0d_zero", which), o_zero, exp_r.zero);
          check($sformatf("st%0d_eff", which), o_eff, exp_r.eff);
          check($sformatf("st%0d_tag", which), o_tag, exp_r.tag);
        end
        got++;
      end
      if (acc) begin
        q.push_back(model(mmax, mmin, sa, sb, max_ab, op_mode, g, s, in_tag));
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid1 = 1'b0; in_valid2 = 1'b0; out_ready1 = 1'b1; out_ready2 = 1'b1;
    #1;
    check($sformatf("st%0d_drained", which), got, nb);
    check($sformatf("st%0d_no_extra", which), o_valid, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid1 = 1'b0; in_valid2 = 1'b0; out_ready1 = 1'b1; out_ready2 = 1'b1;
    mmax = '0; mmin = '0; sa = 0; sb = 0; max_ab = 0; op_mode = 0;
    g = 0; s = 0; in_tag = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int w = 1; w <= 2; w++) begin
      sel = w; #1;
      check($sformatf("rst%0d_valid", w), o_valid, 1'b0);
      check($sformatf("rst%0d_outs", w), {o_sum, o_sgn, o_zero, o_eff, o_tag}, '0);
      check($sformatf("rst%0d_in_ready", w), o_ready, 1'b1);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) run_dir(1, i);
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) run_dir(2, i);
    @(posedge clk); #1;

    stream(1, 6, 1'b1);
    stream(2, 6, 1'b1);
    stream(1, 1000, 1'b0);
    stream(2, 3000, 1'b0);

    // Reset with two beats in flight and a simultaneous accept/consume
    sel = 2;
    out_ready2 = 1'b0;
    drive_vec(0, 8'hA0); in_valid2 = 1'b1;
    @(posedge clk); #1;
    drive_vec(1, 8'hA1);
    @(posedge clk); #1;
    check("mid_two_in_flight", o_valid, 1'b1);
    drive_vec(5, 8'hEE); out_ready2 = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_valid", o_valid, 1'b0);
    check("mid_rst_outs", {o_sum, o_sgn, o_zero, o_eff, o_tag}, '0);
    drive_vec(0, 8'h55);
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    check("post_rst_s1_flushed", o_valid, 1'b0);
    @(posedge clk); #1;
    check("post_rst_valid", o_valid, 1'b1);
    check("post_rst_sum", o_sum, 26'h1800000);
    check("post_rst_tag", o_tag, 8'h55);
    @(posedge clk); #1;
    check("post_rst_no_extra", o_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
